mem_access_ctrl: RTL and testbench

//   Load/store sequencer between the multi-cycle core's MEM stage and the byte-addressable data memory.

---
 rtl/mem_access_ctrl_if.sv | 38 +++
 rtl/mem_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response and data-memory signals of the load/store sequencer.
// slave = the sequencer itself; master = whatever plays core and memory around it.
interface mem_access_ctrl_if #(
    parameter int BUS_WIDTH = 32
);
    // core request
    logic                 req;
    logic                 we;
    logic [2:0]           funct3;
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
    // core response
    logic                 busy;
    logic                 done;
    logic                 fault;
    logic [BUS_WIDTH-1:0] rdata;
    // data memory port
    logic [BUS_WIDTH-1:0] mem_address;
    logic [BUS_WIDTH-1:0] mem_data_in;
    logic                 mem_wr_en;
    logic [1:0]           mem_size;
    logic                 mem_sz_ex;
    logic [BUS_WIDTH-1:0] mem_rdata;
    // memory-mapped output register
    logic [BUS_WIDTH-1:0] io_out;

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output busy, done, fault, rdata,
               mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex, io_out
    );

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  busy, done, fault, rdata,
               mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex, io_out
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and data memory; rejects bad accesses, maps IO_ADDR to io_out.
// Latency: done exactly 3 cycles after an accepted req, rejected or not; req outside IDLE is dropped, not queued.
module mem_access_ctrl #(
    parameter int BUS_WIDTH = 32,
    parameter int MEM_BYTES = 64,
    parameter int IO_ADDR   = 64
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic                 we_q;
    logic [2:0]           funct3_q;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic [1:0]           size_q;
    logic                 sz_ex_q;
    logic                 reject_q;
    logic                 is_io_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic [BUS_WIDTH-1:0] io_reg;

    logic                 legal;
    logic [2:0]           nbytes;
    logic                 misaligned;
    logic                 is_io;
    logic                 io_bad;
    logic [BUS_WIDTH:0]   end_addr;
    logic                 range_bad;
    logic                 reject;

    logic                 busy_c;
    logic                 done_c;
    logic                 fault_c;
    logic                 wr_en_c;

    // Access decode on the latched request; one extra bit on end_addr stops wrap-around past 2^BUS_WIDTH.
    always_comb begin
        legal  = 1'b0;
        nbytes = 3'd4;
        case (funct3_q)
            3'b000:  begin legal = 1'b1;  nbytes = 3'd1; end
            3'b001:  begin legal = 1'b1;  nbytes = 3'd2; end
            3'b010:  begin legal = 1'b1;  nbytes = 3'd4; end
            3'b100:  begin legal = !we_q; nbytes = 3'd1; end
            3'b101:  begin legal = !we_q; nbytes = 3'd2; end
            default: begin legal = 1'b0;  nbytes = 3'd4; end
        endcase
        misaligned = ((nbytes == 3'd2) && addr_q[0]) ||
                     ((nbytes == 3'd4) && (addr_q[1:0] != 2'b00));
        is_io      = (addr_q == BUS_WIDTH'(IO_ADDR));
        io_bad     = is_io && (nbytes != 3'd4);
        end_addr   = {1'b0, addr_q} + (BUS_WIDTH + 1)'(nbytes);
        range_bad  = !is_io && (end_addr > (BUS_WIDTH + 1)'(MEM_BYTES));
        reject     = !legal || misaligned || io_bad || range_bad;
    end

    // Rejected requests still pass through ACCESS (with every side effect suppressed)
    // so the core sees the same completion latency whatever the outcome.
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        fault_c = 1'b0;
        wr_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) state_d = CHECK;
            end
            CHECK: begin
                busy_c  = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                busy_c  = 1'b1;
                wr_en_c = we_q && !reject_q && !is_io_q && !rst;
                state_d = RESP;
            end
            RESP: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                fault_c = reject_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b010;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= 2'b10;
            sz_ex_q  <= 1'b0;
            reject_q <= 1'b0;
            is_io_q  <= 1'b0;
            rdata_q  <= '0;
            io_reg   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        we_q     <= bus.we;
                        funct3_q <= bus.funct3;
                        addr_q   <= bus.addr;
                        wdata_q  <= bus.wdata;
                        size_q   <= (bus.funct3[1:0] == 2'b11) ? 2'b10 : bus.funct3[1:0];
                        sz_ex_q  <= !bus.we && !bus.funct3[2];
                    end
                end
                CHECK: begin
                    reject_q <= reject;
                    is_io_q  <= is_io;
                end
                ACCESS: begin
                    if (reject_q) begin
                        rdata_q <= '0;
                    end else if (is_io_q) begin
                        if (we_q) io_reg  <= wdata_q;
                        else      rdata_q <= io_reg;
                    end else if (!we_q) begin
                        rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.fault       = fault_c;
    assign bus.rdata       = rdata_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.mem_wr_en   = wr_en_c;
    assign bus.mem_size    = size_q;
    assign bus.mem_sz_ex   = sz_ex_q;
    assign bus.io_out      = io_reg;

    a_wr_only_in_access: assert property (@(posedge clk) disable iff (rst)
        bus.mem_wr_en |-> (state_q == ACCESS));
    a_done_single_cycle: assert property (@(posedge clk) disable iff (rst)
        bus.done |=> !bus.done);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised scoreboard bench for mem_access_ctrl: a behavioural memory sits on the mem_* port,
// a byte-array reference model predicts every response, and a negedge monitor checks them.
module tb_mem_access_ctrl;
    localparam int BW        = 32;
    localparam int MEM_BYTES = 64;
    localparam int IO_ADDR   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.BUS_WIDTH(BW)) bus ();

    mem_access_ctrl #(.BUS_WIDTH(BW), .MEM_BYTES(MEM_BYTES), .IO_ADDR(IO_ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int wr_pulses = 0;
    int wr_exp    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: combinational, size/sign-aware read; byte-lane write on the edge.
    logic [7:0]  phys_mem [MEM_BYTES];
    logic [31:0] raw_word;
    logic [31:0] mem_rd;

    always_comb begin
        raw_word = '0;
        mem_rd   = '0;
        for (int i = 0; i < 4; i++)
            if ({32'd0, bus.mem_address} + 64'(i) < 64'(MEM_BYTES))
                raw_word[8*i +: 8] = phys_mem[bus.mem_address[5:0] + 6'(i)];
        case (bus.mem_size)
            2'b00:   mem_rd = bus.mem_sz_ex ? {{24{raw_word[7]}}, raw_word[7:0]}
                                            : {24'd0, raw_word[7:0]};
            2'b01:   mem_rd = bus.mem_sz_ex ? {{16{raw_word[15]}}, raw_word[15:0]}
                                            : {16'd0, raw_word[15:0]};
            default: mem_rd = raw_word;
        endcase
    end
    assign bus.mem_rdata = mem_rd;

    always @(posedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            wr_pulses <= wr_pulses + 1;
            for (int i = 0; i < 4; i++)
                if ((i < (1 << bus.mem_size)) &&
                    ({32'd0, bus.mem_address} + 64'(i) < 64'(MEM_BYTES)))
                    phys_mem[bus.mem_address[5:0] + 6'(i)] <= bus.mem_data_in[8*i +: 8];
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] ref_io    = '0;
    logic [31:0] ref_rdata = '0;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        logic [31:0] io;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("fault",   32'(bus.fault), 32'(e.fault));
                chk("rdata",   bus.rdata, e.rdata);
                chk("io_out",  bus.io_out, e.io);
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Predict from the access rules, then drive one request and wait until the DUT is back in IDLE.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        exp_t        e;
        int          n;
        int          start;
        bit          legal;
        bit          flt;
        bit          seen;
        longint      la;
        logic [31:0] v;
        n     = 1 << f3[1:0];
        legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        la    = longint'({32'd0, a});
        flt   = !legal || (la % n != 0) ||
                ((la == IO_ADDR) ? (n != 4) : (la + n > MEM_BYTES));
        if (flt) begin
            ref_rdata = '0;
        end else if (la == IO_ADDR) begin
            if (w) ref_io = d;
            else   ref_rdata = ref_io;
        end else if (w) begin
            for (int i = 0; i < n; i++) ref_mem[int'(la) + i] = d[8*i +: 8];
            wr_exp++;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(la) + i];
            if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
            ref_rdata = v;
        end
        e.fault = flt;
        e.rdata = ref_rdata;
        e.io    = ref_io;
        e.cyc   = cyc + 3;
        exp_q.push_back(e);

        start      = done_cnt;
        bus.req    = 1'b1;
        bus.we     = w;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = d;
        if (!hold) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = (done_cnt != start);
        end
        bus.req = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout got=none want=done addr=%h funct3=%b", a, f3);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0;
        int          d0;
        logic [7:0]  b;
        logic [31:0] a;
        logic [31:0] got_w;
        logic [31:0] want_w;

        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.funct3 = 3'b000;
        bus.addr   = '0;
        bus.wdata  = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            b           = 8'($urandom);
            phys_mem[i] = b;
            ref_mem[i]  = b;
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_rdata",     bus.rdata, 32'd0);
        chk("reset_mem_size",  32'(bus.mem_size), 32'd2);
        chk("reset_mem_sz_ex", 32'(bus.mem_sz_ex), 32'd0);
        chk("reset_mem_addr",  bus.mem_address, 32'd0);
        repeat (10) begin
            @(negedge clk);
            chk("idle_busy",  32'(bus.busy), 32'd0);
            chk("idle_done",  32'(bus.done), 32'd0);
            chk("idle_io",    bus.io_out, 32'd0);
            chk("idle_wr_en", 32'(bus.mem_wr_en), 32'd0);
        end

        w0 = wr_pulses;
        issue(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 1'b0);
        chk("sw_one_write", 32'(wr_pulses - w0), 32'd1);
        issue(1'b0, 3'b010, 32'd8, 32'h0, 1'b0);
        issue(1'b1, 3'b000, 32'd13, 32'h00000080, 1'b0);
        issue(1'b0, 3'b000, 32'd13, 32'h0, 1'b0);
        issue(1'b0, 3'b100, 32'd13, 32'h0, 1'b0);
        issue(1'b0, 3'b001, 32'd5, 32'h0, 1'b0);
        w0 = wr_pulses;
        issue(1'b1, 3'b010, 32'd62, 32'h12345678, 1'b0);
        chk("sw62_no_write", 32'(wr_pulses - w0), 32'd0);
        issue(1'b0, 3'b011, 32'd8, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 1'b0);
        w0 = wr_pulses;
        issue(1'b1, 3'b010, 32'd64, 32'h5, 1'b0);
        chk("io_store_no_mem_write", 32'(wr_pulses - w0), 32'd0);
        issue(1'b0, 3'b010, 32'd64, 32'h0, 1'b0);
        issue(1'b1, 3'b000, 32'd64, 32'hAA, 1'b0);

        w0 = wr_pulses;
        issue(1'b1, 3'b010, 32'd16, $urandom, 1'b1);
        chk("held_req_one_write", 32'(wr_pulses - w0), 32'd1);

        // Reset landing on the ACCESS cycle of a store must leave memory untouched.
        w0         = wr_pulses;
        d0         = done_cnt;
        bus.req    = 1'b1;
        bus.we     = 1'b1;
        bus.funct3 = 3'b010;
        bus.addr   = 32'd0;
        bus.wdata  = ~{ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        ref_io    = '0;
        ref_rdata = '0;
        repeat (4) @(negedge clk);
        chk("abort_no_write", 32'(wr_pulses - w0), 32'd0);
        chk("abort_no_done",  32'(done_cnt - d0), 32'd0);
        chk("abort_io_reset", bus.io_out, 32'd0);
        got_w  = {phys_mem[3], phys_mem[2], phys_mem[1], phys_mem[0]};
        want_w = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
        chk("abort_word0", got_w, want_w);
        issue(1'b0, 3'b010, 32'd0, 32'h0, 1'b0);

        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 70));
                1:       a = 32'(IO_ADDR);
                2:       a = 32'($urandom_range(56, 66));
                default: a = $urandom;
            endcase
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                  ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("total_writes", 32'(wr_pulses), 32'(wr_exp));
        chk("pending_responses", 32'(exp_q.size()), 32'd0);
        d0 = 0;
        for (int i = 0; i < MEM_BYTES; i++)
            if (phys_mem[i] !== ref_mem[i]) d0++;
        chk("mem_image_diff_bytes", 32'(d0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
